// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and receiver.
//   serial_state_e : frame FSM states
//   LINE_IDLE / START_BIT / STOP_BIT : line levels
//   cnt_width()    : counter width for a modulus of n (minimum 1 bit)
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } serial_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Width of a counter that must hold 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer shared by the serial transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 while running and raises bit_end during the
// last clock of each bit period.
//   clock   : system clock, rising edge
//   reset   : asynchronous active-high reset
//   clear   : restart the count at the beginning of a bit period
//   run     : a frame is in progress; count advances every clock
//   bit_end : registered strobe, high in the final clock of a bit
module serial_bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic bit_end
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             bit_end_n;

    // Next count: restart on clear, wrap at the bit boundary, park at 0 when idle.
    always_comb begin
        cnt_n     = '0;
        bit_end_n = 1'b0;
        if (clear) begin
            cnt_n = '0;
        end else if (run) begin
            cnt_n = (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
        end
        // Strobe is registered, so it is decoded from the count about to be loaded.
        bit_end_n = (clear || run) && (cnt_n == LAST_CNT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_end <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            bit_end <= bit_end_n;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W data bits LSB first,
// optional even-parity bit, stop bit; each bit held CLKS_PER_BIT clocks.
// Build option: define SERIAL_TX_PARITY_EN to insert the parity bit.
//   clock    : system clock, rising edge
//   reset    : asynchronous active-high reset
//   tx_data  : payload, sampled only on acceptance
//   tx_valid : payload offered
//   tx_ready : block can accept a payload (registered)
//   txd      : serial line, idles high (registered)
//   busy     : frame in progress (registered)
//   done     : one-cycle pulse in the first idle cycle after a frame (registered)
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      BIT_W    = cnt_width(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    serial_state_e     state;
    serial_state_e     state_n;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_cnt_n;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_n;
    logic              txd_n;
    logic              done_n;
    logic              accept_c;
    logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity;
    logic              parity_n;
`endif

    // tx_ready is only high in IDLE, so this is the acceptance edge.
    assign accept_c = tx_valid && tx_ready;

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept_c),
        .run     (state != IDLE),
        .bit_end (bit_end)
    );

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        done_n    = 1'b0;
        txd_n     = LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
        parity_n  = parity;
`endif

        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_n   = START;
                    shift_n   = tx_data;
                    bit_cnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_n  = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered, so the line level follows the state being entered.
        case (state_n)
            IDLE:    txd_n = LINE_IDLE;
            START:   txd_n = START_BIT;
            DATA:    txd_n = shift_n[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  txd_n = parity_n;
`endif
            STOP:    txd_n = STOP_BIT;
            default: txd_n = LINE_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Even parity of the accepted payload.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity <= 1'b0;
        end else begin
            parity <= parity_n;
        end
    end
`endif

    // Output registers; reset forces the line high immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txd      <= LINE_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            txd      <= txd_n;
            tx_ready <= (state_n == IDLE);
            busy     <= (state_n != IDLE);
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: DUT a uses CLKS_PER_BIT=4, DUT b uses
// CLKS_PER_BIT=1; both DATA_W=8. Status nibble is {txd, tx_ready, busy, done}.
// Parity expectations follow SERIAL_TX_PARITY_EN.
module tb_serial_tx;

    localparam int unsigned DW = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic [DW-1:0] data_a, data_b;
    logic          valid_a, valid_b;
    logic          ready_a, ready_b;
    logic          txd_a, txd_b;
    logic          busy_a, busy_b;
    logic          done_a, done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) dut_a (
        .clock    (clk),
        .reset    (rst),
        .tx_data  (data_a),
        .tx_valid (valid_a),
        .tx_ready (ready_a),
        .txd      (txd_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut_b (
        .clock    (clk),
        .reset    (rst),
        .tx_data  (data_b),
        .tx_valid (valid_b),
        .tx_ready (ready_b),
        .txd      (txd_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] status(input int w);
        if (w == 0) return {txd_a, ready_a, busy_a, done_a};
        return {txd_b, ready_b, busy_b, done_b};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [DW-1:0] d);
        if (w == 0) begin
            valid_a = v;
            data_a  = d;
        end else begin
            valid_b = v;
            data_b  = d;
        end
    endtask

    // Offer a payload for one edge, then scramble the data bus.
    task automatic start(input int w, input logic [DW-1:0] d);
        drive(w, 1'b1, d);
        tick();
        drive(w, 1'b0, ~d);
    endtask

    // From the cycle after acceptance: every bit for cpb cycles, then the done cycle.
    task automatic expect_frame(input int w, input logic [DW-1:0] d, input int cpb, input string tag);
        logic [DW+2:0] bits;
        int n;
        n = int'(DW) + 2 + int'(PB);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < int'(DW); i++) bits[i+1] = d[i];
        if (PB == 1) bits[DW+1] = ^d;
        bits[n-1] = 1'b1;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < cpb; c++) begin
                check($sformatf("%s bit%0d clk%0d", tag, b, c), status(w),
                      {bits[b], 1'b0, 1'b1, 1'b0});
                tick();
            end
        end
        check($sformatf("%s done", tag), status(w), 4'b1101);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        tick();
        check("reset_a", status(0), 4'b1100);
        check("reset_b", status(1), 4'b1100);
        rst = 1'b0;
        tick();
        check("idle_a", status(0), 4'b1100);

        // 1: short mid-cycle reset pulse
        #3 rst = 1'b1;
        #1 check("rst_pulse_a", status(0), 4'b1100);
        check("rst_pulse_b", status(1), 4'b1100);
        #4 rst = 1'b0;
        tick();
        check("rst_release_a", status(0), 4'b1100);

        // 2: single frame 8'hA5
        start(0, 8'hA5);
        expect_frame(0, 8'hA5, 4, "a5");
        tick();
        check("a5_after_done", status(0), 4'b1100);

        // 3: back-to-back, 8'h3C held valid throughout the first frame
        start(0, 8'hA5);
        drive(0, 1'b1, 8'h3C);
        expect_frame(0, 8'hA5, 4, "b2b_first");
        tick();
        drive(0, 1'b0, 8'h00);
        expect_frame(0, 8'h3C, 4, "b2b_second");
        tick();
        check("b2b_idle", status(0), 4'b1100);

        // 4: reset during data bit 3, then a clean 8'h81
        start(0, 8'h00);
        repeat (4 + 3 * 4 + 1) tick();
        check("mid_bit3", status(0), 4'b0010);
        #3 rst = 1'b1;
        #1 check("mid_rst_async", status(0), 4'b1100);
        #4 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("mid_rst_idle%0d", i), status(0), 4'b1100);
        end
        start(0, 8'h81);
        expect_frame(0, 8'h81, 4, "x81");
        tick();

        // 5: odd-weight payload, then reset during its done cycle
        start(0, 8'h07);
        expect_frame(0, 8'h07, 4, "x07");
        #3 rst = 1'b1;
        #1 check("done_rst_clear", status(0), 4'b1100);
        #4 rst = 1'b0;
        tick();
        check("done_rst_idle", status(0), 4'b1100);

        // 6: one clock per bit
        start(1, 8'hFF);
        expect_frame(1, 8'hFF, 1, "cpb1_ff");
        tick();
        check("cpb1_idle", status(1), 4'b1100);
        start(1, 8'h5A);
        expect_frame(1, 8'h5A, 1, "cpb1_5a");
        tick();
        check("cpb1_idle2", status(1), 4'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
